// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the buffered write-back register file.
// Holds datapath widths, write-FIFO sizing, the write-entry record and the
// architectural reset value used by regfile_wb and wb_fifo.
package regfile_wb_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned NUM_REGS  = 4;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned BUF_DEPTH = 2;

    // Pointer indexes a slot; the count must also represent "full" (BUF_DEPTH).
    localparam int unsigned BUF_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [DATA_W-1:0] REG_RESET_VAL = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back FIFO: buffers accepted writes until they are committed to the
// register array. Every slot and its valid bit are exposed so the read ports
// can bypass pending data.
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset
//   push_i          - enqueue push_entry_i at the write pointer
//   push_entry_i    - {addr, data} to enqueue
//   pop_i           - retire the oldest entry (caller guarantees non-empty)
//   entries_o       - all slot contents
//   valid_o         - per-slot valid bits
//   rd_ptr_o        - slot index of the oldest entry
//   head_o          - oldest entry (slot at rd_ptr_o)
//   count_o         - registered occupancy, 0..BUF_DEPTH
//   empty_o, full_o - registered empty flag, full derived from registered count
module wb_fifo
    import regfile_wb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  wr_entry_t            push_entry_i,
    input  logic                 pop_i,
    output wr_entry_t            entries_o [BUF_DEPTH],
    output logic [BUF_DEPTH-1:0] valid_o,
    output logic [BUF_PTR_W-1:0] rd_ptr_o,
    output wr_entry_t            head_o,
    output logic [BUF_CNT_W-1:0] count_o,
    output logic                 empty_o,
    output logic                 full_o
);

    wr_entry_t            entries_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] valid_q;
    logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [BUF_CNT_W-1:0] count_q, count_d;
    logic                 empty_q, empty_d;

    function automatic logic [BUF_PTR_W-1:0] ptr_inc(input logic [BUF_PTR_W-1:0] p);
        return (p == BUF_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + BUF_PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + BUF_CNT_W'(1);
            2'b01:   count_d = count_q - BUF_CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
    end

    // Push and pop never target the same slot: push needs !full, pop needs
    // !empty, and the pointers only coincide when one of those holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            valid_q  <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push_i) begin
                entries_q[wr_ptr_q] <= push_entry_i;
                valid_q[wr_ptr_q]   <= 1'b1;
            end
        end
    end

    assign entries_o = entries_q;
    assign valid_o   = valid_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign head_o    = entries_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = empty_q;
    assign full_o    = (count_q == BUF_CNT_W'(BUF_DEPTH));

endmodule

// File: rtl/regfile_wb.sv
// 4 x 8-bit register file with a buffered write-back port. Writes (from the
// MUX output) are queued in wb_fifo and committed to the array when CommitEn
// allows; the two combinational read ports see pending writes via bypass,
// the youngest matching FIFO entry taking priority over the array.
// Ports:
//   Clk, Reset         - clock, synchronous active-high reset
//   WrValid / WrReady  - write handshake; WrReady = !full & !Reset
//   WrAddr, WrData     - write destination and data
//   CommitEn           - permit the oldest FIFO entry to retire this cycle
//   RdAddrA/B, RdDataA/B - independent zero-latency read ports
//   BufCount, BufEmpty - registered FIFO occupancy and empty flag
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrValid,
    output logic              WrReady,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              CommitEn,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] RdDataA,
    output logic [DATA_W-1:0] RdDataB,
    output logic [ADDR_W-1:0] BufCount,
    output logic              BufEmpty
);

    logic [DATA_W-1:0]    regs_q [NUM_REGS];

    wr_entry_t            fifo_entries [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] fifo_valid;
    logic [BUF_PTR_W-1:0] fifo_rd_ptr;
    wr_entry_t            fifo_head;
    logic [BUF_CNT_W-1:0] fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;

    logic                 push;
    logic                 pop;
    wr_entry_t            push_entry;

    assign WrReady    = !fifo_full && !Reset;
    assign push       = WrValid && WrReady;
    assign pop        = CommitEn && !fifo_empty && !Reset;
    assign push_entry = '{addr: WrAddr, data: WrData};

    wb_fifo u_fifo (
        .clk_i        (Clk),
        .rst_i        (Reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .entries_o    (fifo_entries),
        .valid_o      (fifo_valid),
        .rd_ptr_o     (fifo_rd_ptr),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_RESET_VAL;
            end
        end else if (pop) begin
            regs_q[fifo_head.addr] <= fifo_head.data;
        end
    end

    // Walk the FIFO oldest-to-youngest starting at the read pointer; a later
    // match overrides an earlier one, so the youngest pending write wins.
    always_comb begin
        logic [BUF_PTR_W-1:0] idx;
        idx     = '0;
        RdDataA = regs_q[RdAddrA];
        RdDataB = regs_q[RdAddrB];
        for (int unsigned k = 0; k < BUF_DEPTH; k++) begin
            idx = BUF_PTR_W'((32'(fifo_rd_ptr) + k) % BUF_DEPTH);
            if (fifo_valid[idx] && (fifo_entries[idx].addr == RdAddrA)) begin
                RdDataA = fifo_entries[idx].data;
            end
            if (fifo_valid[idx] && (fifo_entries[idx].addr == RdAddrB)) begin
                RdDataB = fifo_entries[idx].data;
            end
        end
    end

    assign BufCount = ADDR_W'(fifo_count);
    assign BufEmpty = fifo_empty;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb. A behavioural model (array plus an
// ordered queue of pending writes) predicts every observable; expectations
// are queued as each cycle's stimulus is driven and popped against the DUT
// before the edge (combinational reads / WrReady) and just after it.
module tb_regfile_wb;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       WrValid;
    logic       WrReady;
    logic [1:0] WrAddr;
    logic [7:0] WrData;
    logic       CommitEn;
    logic [1:0] RdAddrA;
    logic [1:0] RdAddrB;
    logic [7:0] RdDataA;
    logic [7:0] RdDataB;
    logic [1:0] BufCount;
    logic       BufEmpty;

    always #5 Clk = ~Clk;

    regfile_wb dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .CommitEn (CommitEn),
        .RdAddrA  (RdAddrA),
        .RdAddrB  (RdAddrB),
        .RdDataA  (RdDataA),
        .RdDataB  (RdDataB),
        .BufCount (BufCount),
        .BufEmpty (BufEmpty)
    );

    typedef enum {K_RDA, K_RDB, K_CNT, K_EMP, K_RDY} kind_e;
    typedef struct { kind_e kind; logic [7:0] val; } exp_t;
    typedef struct { logic [1:0] addr; logic [7:0] data; } ment_t;

    exp_t       exp_q[$];
    ment_t      mfifo[$];
    logic [7:0] mregs [4];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [1:0] a);
        logic [7:0] r;
        r = mregs[a];
        foreach (mfifo[i]) begin
            if (mfifo[i].addr == a) r = mfifo[i].data;
        end
        return r;
    endfunction

    function automatic logic m_ready(input logic rst);
        return !rst && (mfifo.size() < 2);
    endfunction

    task automatic want(input kind_e k, input logic [7:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string phase);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_RDA: check({phase, "/RdDataA"}, RdDataA, e.val);
                K_RDB: check({phase, "/RdDataB"}, RdDataB, e.val);
                K_CNT: check({phase, "/BufCount"}, {6'b0, BufCount}, e.val);
                K_EMP: check({phase, "/BufEmpty"}, {7'b0, BufEmpty}, e.val);
                default: check({phase, "/WrReady"}, {7'b0, WrReady}, e.val);
            endcase
        end
    endtask

    task automatic cycle(input string name, input logic rst, input logic wv,
                         input logic [1:0] wa, input logic [7:0] wd, input logic ce,
                         input logic [1:0] ra, input logic [1:0] rb);
        bit    acc;
        bit    ret;
        ment_t ent;
        @(negedge Clk);
        Reset    = rst;
        WrValid  = wv;
        WrAddr   = wa;
        WrData   = wd;
        CommitEn = ce;
        RdAddrA  = ra;
        RdAddrB  = rb;
        #1;
        want(K_RDY, {7'b0, m_ready(rst)});
        want(K_RDA, m_read(ra));
        want(K_RDB, m_read(rb));
        drain({name, ":pre"});

        acc = wv && m_ready(rst);
        ret = ce && !rst && (mfifo.size() > 0);
        if (rst) begin
            foreach (mregs[i]) mregs[i] = 8'h00;
            mfifo.delete();
        end else begin
            if (ret) begin
                ent = mfifo.pop_front();
                mregs[ent.addr] = ent.data;
            end
            if (acc) begin
                ent.addr = wa;
                ent.data = wd;
                mfifo.push_back(ent);
            end
        end
        want(K_RDY, {7'b0, m_ready(rst)});
        want(K_RDA, m_read(ra));
        want(K_RDB, m_read(rb));
        want(K_CNT, 8'(mfifo.size()));
        want(K_EMP, {7'b0, mfifo.size() == 0});

        @(posedge Clk);
        #1;
        drain({name, ":post"});
    endtask

    initial begin
        Reset    = 1'b1;
        WrValid  = 1'b0;
        WrAddr   = '0;
        WrData   = '0;
        CommitEn = 1'b0;
        RdAddrA  = '0;
        RdAddrB  = '0;
        repeat (2) @(posedge Clk);
        foreach (mregs[i]) mregs[i] = 8'h00;

        // reset state and all four addresses
        cycle("rst",      1, 0, 0, 8'h00, 0, 0, 1);
        cycle("idle01",   0, 0, 0, 8'h00, 0, 0, 1);
        cycle("idle23",   0, 0, 0, 8'h00, 0, 2, 3);
        // bypass of a pending write, then commit
        cycle("wr_r1",    0, 1, 1, 8'h5A, 0, 1, 1);
        cycle("cm_r1",    0, 0, 0, 8'h00, 1, 1, 0);
        // two writes to the same address fill the FIFO; younger wins
        cycle("wr_r2a",   0, 1, 2, 8'h11, 0, 2, 2);
        cycle("wr_r2b",   0, 1, 2, 8'h22, 0, 2, 2);
        cycle("rd_r2",    0, 0, 0, 8'h00, 0, 0, 2);
        cycle("cm_r2a",   0, 0, 0, 8'h00, 1, 2, 2);
        cycle("cm_r2b",   0, 0, 0, 8'h00, 1, 2, 2);
        // full with commit and WrValid held: no same-cycle pass-through
        cycle("fill1",    0, 1, 1, 8'h33, 0, 1, 0);
        cycle("fill0",    0, 1, 0, 8'h44, 0, 1, 0);
        cycle("full_cm",  0, 1, 3, 8'hC3, 1, 3, 0);
        cycle("acc_r3",   0, 1, 3, 8'hC3, 1, 3, 0);
        cycle("cm_r3",    0, 0, 0, 8'h00, 1, 3, 1);
        cycle("rd_r3",    0, 0, 0, 8'h00, 0, 3, 2);
        // reset discards pending entries
        cycle("pend0",    0, 1, 0, 8'h77, 0, 0, 1);
        cycle("pend1",    0, 1, 1, 8'h88, 0, 0, 1);
        cycle("rst_mid",  1, 1, 2, 8'h99, 1, 0, 1);
        cycle("post_rst", 0, 0, 0, 8'h00, 1, 0, 1);
        // both ports on the same address
        cycle("wr_r0",    0, 1, 0, 8'hFF, 0, 0, 0);
        cycle("both_r0",  0, 0, 0, 8'h00, 1, 0, 0);
        cycle("both_r0b", 0, 0, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            cycle("rand", ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 4-entry x 8-bit register file with a buffered write-back port.
- Sits on both sides of the 8-bit 2:1 MUX stage:
  - its two read ports drive the MUX's Input1/Input2;
  - the MUX's MUXOutput comes back as the write-back data.
- A small write FIFO decouples write-back from commit. Reads bypass the FIFO, so pending writes are visible immediately.

Parameters:
- DATA_W, 8, data width (matches the MUX's 8-bit path)
- NUM_REGS, 4, number of architectural registers
- ADDR_W, 2, register address width (log2 NUM_REGS)
- BUF_DEPTH, 2, write FIFO entries (power of two)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- WrValid  input  1  write request valid
- WrReady  output  1  write request accepted when WrValid & WrReady
- WrAddr  input  ADDR_W  destination register
- WrData  input  DATA_W  write data (from MUXOutput)
- CommitEn  input  1  allow the oldest FIFO entry to retire this cycle
- RdAddrA  input  ADDR_W  read port A address
- RdAddrB  input  ADDR_W  read port B address
- RdDataA  output  DATA_W  read port A data (to MUX Input1)
- RdDataB  output  DATA_W  read port B data (to MUX Input2)
- BufCount  output  ADDR_W  number of FIFO entries, 0..BUF_DEPTH
- BufEmpty  output  1  FIFO empty

Behaviour:
- Clock and reset:
  - One clock domain (Clk).
  - Reset is synchronous and active-high.
- Reset (sampled at a rising edge of Clk):
  - all registers become 0x00;
  - FIFO read/write pointers and count become 0;
  - BufEmpty=1, BufCount=0.
  - While Reset is high, WrReady=0 and writes are dropped.
  - Reset asserted mid-operation discards pending FIFO entries; they never reach the array.
- Enqueue:
  - Occurs on an edge where WrValid & WrReady.
  - {WrAddr, WrData} is stored at the write pointer.
  - Write pointer wraps modulo BUF_DEPTH.
- WrReady:
  - WrReady = !full & !Reset, combinational from registered count.
  - No pass-through when full: a simultaneous retire does not raise WrReady in the same cycle.
- Retire:
  - Occurs on an edge where CommitEn & !BufEmpty.
  - The oldest entry is written into the array.
  - Read pointer advances, wrapping modulo BUF_DEPTH.
  - One retire per cycle maximum.
- Simultaneous enqueue and retire:
  - count is unchanged;
  - both pointers advance.
- Count and flags:
  - Count range is 0..BUF_DEPTH.
  - BufCount and BufEmpty are registered and reflect the post-edge state.
  - BUF_DEPTH=2 fits ADDR_W=2.
- Reads are combinational, zero latency. For each port, RdData resolves as:
  - the youngest valid FIFO entry with a matching address; otherwise
  - the array value.
- Read bypass cases:
  - Same-cycle enqueue data is not bypassed; it becomes visible the cycle after acceptance.
  - An entry retiring on the current edge still supplies bypass data before the edge; after the edge the array holds the same value, so there is no glitch in architectural value.
  - Two FIFO entries to the same address: the younger wins on read and retires last, so the array ends with the younger value.
- Ports A and B are independent; both may read the same address.
- No arithmetic beyond pointer and count increments. All data paths are DATA_W wide with no truncation.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, NUM_REGS;
  - a write-entry struct {addr[ADDR_W], data[DATA_W]};
  - the reset value constant 8'h00.
- One natural sub-module: wb_fifo, which holds pointers, count, entry storage and a valid vector, and exposes all entries for bypass lookup.
- The array, bypass priority mux and top-level glue live in regfile_wb.

Test Plan:
- Reset then read all 4 addresses -> RdDataA/B=0x00; BufEmpty=1; WrReady=1 after Reset deasserts.
- CommitEn=0; write r1=0x5A -> next cycle RdDataA(r1)=0x5A via bypass; BufCount=1.
- Then CommitEn=1 -> next cycle RdDataA(r1) still 0x5A; BufEmpty=1.
- CommitEn=0; write r2=0x11 then r2=0x22 -> WrReady=0 (full).
- Then RdDataB(r2)=0x22.
- Then enable commit for 2 cycles -> array r2=0x22; BufCount 2->1->0.
- Full FIFO with CommitEn=1 and WrValid held -> one retire; WrReady rises the following cycle, not the same cycle.
- Next write r3=0xC3 is accepted, and pointers wrap correctly: r3 reads 0xC3.
- Two entries pending; assert Reset for 1 cycle -> all reads 0x00; BufCount=0; pending data never appears.
- RdAddrA=RdAddrB=r0 after writing r0=0xFF -> both ports read 0xFF.
